// File: rtl/tl45_isa_pkg.sv
// TL45 ISA definitions shared by the decode stage: opcode table, field
// positions, the decoded-instruction record and the field-split function.
package tl45_isa_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 4;

  // Instruction field positions
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int RI_BIT  = 26;
  localparam int DR_HI   = 25;
  localparam int DR_LO   = 22;
  localparam int SR1_HI  = 21;
  localparam int SR1_LO  = 18;
  localparam int SR2_HI  = 17;
  localparam int SR2_LO  = 14;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int IMM_W   = IMM_HI - IMM_LO + 1;

  // Defined opcodes; any other 5-bit value is undefined
  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_MUL  = 5'h03,
    OP_DIV  = 5'h04,
    OP_AND  = 5'h05,
    OP_OR   = 5'h06,
    OP_XOR  = 5'h07,
    OP_SHL  = 5'h08,
    OP_SHR  = 5'h09,
    OP_SAR  = 5'h0A,
    OP_JMP  = 5'h0C,
    OP_CALL = 5'h0D,
    OP_RET  = 5'h0E,
    OP_LW   = 5'h14,
    OP_SW   = 5'h15,
    OP_IN   = 5'h18,
    OP_OUT  = 5'h19
  } opcode_t;

  // Occupancy of the output + skid pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       opcode;
    logic             ri;
    logic [REG_W-1:0] dr;
    logic [REG_W-1:0] sr1;
    logic [REG_W-1:0] sr2;
    logic [XLEN-1:0]  imm32;
    logic             illegal;
  } decoded_t;

  // LOGIC group: bitwise ops take a zero-extended immediate
  function automatic logic is_logic_op(input logic [4:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  function automatic logic is_defined_op(input logic [4:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_SAR, OP_JMP, OP_CALL, OP_RET, OP_LW, OP_SW,
      OP_IN, OP_OUT: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic decoded_t decode(input logic [XLEN-1:0] pc,
                                      input logic [31:0]     inst);
    decoded_t d;
    d.pc      = pc;
    d.opcode  = inst[OPC_HI:OPC_LO];
    d.ri      = inst[RI_BIT];
    d.dr      = inst[DR_HI:DR_LO];
    d.sr1     = inst[SR1_HI:SR1_LO];
    // sr2 overlaps the immediate; it is split out regardless of ri
    d.sr2     = inst[SR2_HI:SR2_LO];
    if (is_logic_op(inst[OPC_HI:OPC_LO]))
      d.imm32 = {{(XLEN-IMM_W){1'b0}}, inst[IMM_HI:IMM_LO]};
    else
      d.imm32 = {{(XLEN-IMM_W){inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};
    d.illegal = !is_defined_op(inst[OPC_HI:OPC_LO]);
    return d;
  endfunction

endpackage

// File: rtl/tl45_decode.sv
// TL45 decode stage. Splits the prefetch {pc, inst} word into fields held in
// an output register, with a one-entry skid so the upstream stall is a flop.
// Optional feature macro: TL45_DECODE_ILLEGAL_TRAP_EN adds the o_illegal flag.
module tl45_decode
  import tl45_isa_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pipe_stall,
  input  logic             i_pipe_flush,
  output logic             o_pipe_stall,
  input  logic [XLEN-1:0]  i_buf_pc,
  input  logic [31:0]      i_buf_inst,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_pc,
  output logic [4:0]       o_opcode,
  output logic             o_ri,
  output logic [REG_W-1:0] o_dr,
  output logic [REG_W-1:0] o_sr1,
  output logic [REG_W-1:0] o_sr2,
  output logic [XLEN-1:0]  o_imm32
`ifdef TL45_DECODE_ILLEGAL_TRAP_EN
  ,
  output logic             o_illegal
`endif
);

  state_t   r_state;
  decoded_t r_out;
  decoded_t r_skid;
  logic     r_valid;
  logic     r_stall;

  decoded_t w_dec;
  logic     w_accept;
  logic     w_drain;

  // Zero word is a bubble; nothing is taken while the skid is full or flushing
  assign w_accept = (i_buf_inst != 32'd0) && !r_stall && !i_pipe_flush;
  assign w_drain  = r_valid && !i_pipe_stall;
  assign w_dec    = decode(i_buf_pc, i_buf_inst);

  // Occupancy FSM with registered valid/stall and the two decoded registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
    end else if (i_pipe_flush) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out   <= w_dec;
            r_valid <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_out <= w_dec;
          end else if (w_accept) begin
            // Downstream is holding: park the word the prefetch already released
            r_skid  <= w_dec;
            r_stall <= 1'b1;
            r_state <= ST_TWO;
          end else if (w_drain) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_out   <= r_skid;
            r_skid  <= '0;
            r_stall <= 1'b0;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign o_pipe_stall = r_stall;
  assign o_valid      = r_valid;
  assign o_pc         = r_out.pc;
  assign o_opcode     = r_out.opcode;
  assign o_ri         = r_out.ri;
  assign o_dr         = r_out.dr;
  assign o_sr1        = r_out.sr1;
  assign o_sr2        = r_out.sr2;
  assign o_imm32      = r_out.imm32;

`ifdef TL45_DECODE_ILLEGAL_TRAP_EN
  assign o_illegal = r_valid && r_out.illegal;
`else
  // Flag bit is carried in the record but has no consumer in this build
  logic w_unused_illegal;
  assign w_unused_illegal = r_out.illegal;
`endif

endmodule
